// File: rtl/block_field_store.sv
// ---------------------------------------------------------------------------
// block_field_store
//   One-bit-per-brick alive/dead store for the Breakout brick field.
//   A writer port (game controller) kills bricks and requests refills; an
//   independent read-only port serves the renderer. A running count of
//   surviving bricks and a level-cleared flag are maintained alongside.
//
// Parameters
//   ADDR_BITS   brick address width; 2**ADDR_BITS entries
//   NUM_BLOCKS  playable bricks at addresses 0..NUM_BLOCKS-1
//
// Ports
//   CLK          system clock
//   RESET_N      asynchronous active-low reset
//   RD_ADDR      renderer scan address
//   RD_ALIVE     registered alive bit for RD_ADDR (0 while sweeping)
//   CTL_ADDR     controller query/kill address
//   CTL_ALIVE    registered alive bit for CTL_ADDR (0 while sweeping)
//   KILL_REQ     kill request level, sampled only when idle
//   KILL_ACK     one-cycle kill completion pulse
//   KILL_HIT     brick was alive before the kill; holds between kills
//   REFILL       refill request pulse (ignored while sweeping)
//   READY        store idle
//   ALIVE_COUNT  surviving brick count
//   CLEARED      READY and no bricks left
// ---------------------------------------------------------------------------
module block_field_store #(
    parameter int unsigned ADDR_BITS  = 7,
    parameter int unsigned NUM_BLOCKS = 112
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [ADDR_BITS-1:0] RD_ADDR,
    output logic                 RD_ALIVE,
    input  logic [ADDR_BITS-1:0] CTL_ADDR,
    output logic                 CTL_ALIVE,
    input  logic                 KILL_REQ,
    output logic                 KILL_ACK,
    output logic                 KILL_HIT,
    input  logic                 REFILL,
    output logic                 READY,
    output logic [ADDR_BITS:0]   ALIVE_COUNT,
    output logic                 CLEARED
);

    localparam int unsigned           DEPTH        = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR    = '1;
    localparam logic [ADDR_BITS-1:0]  ADDR_ONE     = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]    CNT_ONE      = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS:0]    NUM_BLOCKS_W = (ADDR_BITS + 1)'(NUM_BLOCKS);

    typedef enum logic [1:0] {
        S_SWEEP,
        S_IDLE,
        S_KILL_RD,
        S_KILL_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [DEPTH-1:0]       r_mem;
    logic [ADDR_BITS-1:0]   r_cnt;
    logic [ADDR_BITS-1:0]   r_kill_addr;
    logic [ADDR_BITS:0]     r_alive_count;
    logic                   r_refill_pend;
    logic                   r_rd_alive;
    logic                   r_ctl_alive;
    logic                   r_kill_ack;
    logic                   r_kill_hit;

    logic                   w_refill_req;
    logic                   w_sweep_wr;
    logic                   w_sweep_bit;
    logic                   w_enter_sweep;
    logic                   w_start_kill;
    logic                   w_kill_wr;
    logic                   w_old_bit;
    logic                   w_sweeping;

    // A REFILL pulse arriving in IDLE counts as pending in that same cycle,
    // which is what gives refill priority over a simultaneous KILL_REQ.
    assign w_refill_req = r_refill_pend | REFILL;
    assign w_sweep_bit  = ({1'b0, r_cnt} < NUM_BLOCKS_W);
    assign w_old_bit    = r_mem[r_kill_addr];
    assign w_sweeping   = (r_state == S_SWEEP);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_SWEEP;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and datapath strobes
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_sweep_wr    = 1'b0;
        w_enter_sweep = 1'b0;
        w_start_kill  = 1'b0;
        w_kill_wr     = 1'b0;
        case (r_state)
            S_SWEEP: begin
                w_sweep_wr = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_refill_req) begin
                    w_next_state  = S_SWEEP;
                    w_enter_sweep = 1'b1;
                end else if (KILL_REQ) begin
                    w_next_state = S_KILL_RD;
                    w_start_kill = 1'b1;
                end
            end
            S_KILL_RD: begin
                w_kill_wr    = 1'b1;
                w_next_state = S_KILL_DONE;
            end
            S_KILL_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_SWEEP;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: brick store, sweep counter, alive count, kill handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mem         <= '0;
            r_cnt         <= '0;
            r_kill_addr   <= '0;
            r_alive_count <= '0;
            r_refill_pend <= 1'b0;
            r_rd_alive    <= 1'b0;
            r_ctl_alive   <= 1'b0;
            r_kill_ack    <= 1'b0;
            r_kill_hit    <= 1'b0;
        end else begin
            // Read-first: both ports capture the pre-write contents.
            r_rd_alive  <= r_mem[RD_ADDR];
            r_ctl_alive <= r_mem[CTL_ADDR];
            r_kill_ack  <= 1'b0;

            if (w_sweep_wr) begin
                r_mem[r_cnt] <= w_sweep_bit;
                r_cnt        <= r_cnt + ADDR_ONE;
                if (w_sweep_bit) begin
                    r_alive_count <= r_alive_count + CNT_ONE;
                end
            end

            if (w_enter_sweep) begin
                r_cnt         <= '0;
                r_alive_count <= '0;
            end

            if (w_start_kill) begin
                r_kill_addr <= CTL_ADDR;
            end

            if (w_kill_wr) begin
                r_mem[r_kill_addr] <= 1'b0;
                r_kill_ack         <= 1'b1;
                r_kill_hit         <= w_old_bit;
                if (w_old_bit && (r_alive_count != '0)) begin
                    r_alive_count <= r_alive_count - CNT_ONE;
                end
            end

            if (w_enter_sweep) begin
                r_refill_pend <= 1'b0;
            end else if (!w_sweeping && REFILL) begin
                r_refill_pend <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign RD_ALIVE    = r_rd_alive & ~w_sweeping;
    assign CTL_ALIVE   = r_ctl_alive & ~w_sweeping;
    assign KILL_ACK    = r_kill_ack;
    assign KILL_HIT    = r_kill_hit;
    assign READY       = (r_state == S_IDLE);
    assign ALIVE_COUNT = r_alive_count;
    assign CLEARED     = READY & (r_alive_count == '0);

endmodule
